// File: rtl/spi_aes_slave_if.sv
// spi_aes_slave_if
// Slave-side serial front end for one AES node. Collects an MSB-first
// {message,key} frame on mosi while cs_n is low, hands it to the AES core
// with a start/done handshake and returns the core result MSB-first on
// miso. data_done is high for exactly MSG_W cycles while miso is valid.
module spi_aes_slave_if #(
  parameter int MSG_W = 128,
  parameter int KEY_W = 256
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             data_done,
  output logic             core_start,
  output logic [MSG_W-1:0] core_msg,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_done,
  input  logic [MSG_W-1:0] core_result,
  output logic             busy,
  output logic             rx_err
);

  localparam int FRM_W = MSG_W + KEY_W;
  localparam int CNT_W = $clog2(FRM_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RX    = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Count value at which the current RX edge samples the final frame bit.
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(FRM_W - 1);
  // Count value once all MSG_W result bits have been driven.
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(MSG_W);

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             armed_r;
  // Only FRM_W-1 bits are stored: the final bit comes straight from mosi.
  logic [FRM_W-2:0] rx_sreg_r;
  logic [FRM_W-1:0] rx_shift_s;
  logic [MSG_W-1:0] tx_sreg_r;
  logic             miso_r;
  logic             data_done_r;
  logic             core_start_r;
  logic [MSG_W-1:0] core_msg_r;
  logic [KEY_W-1:0] core_key_r;
  logic             busy_r;
  logic             rx_err_r;

  logic             frame_begin_s;
  logic             rx_abort_s;
  logic             rx_bit_s;
  logic             rx_last_s;
  logic             result_take_s;
  logic             tx_end_s;
  logic             tx_bit_s;

  // Decode the per-edge events that drive every register below.
  always_comb begin
    frame_begin_s = 1'b0;
    rx_abort_s    = 1'b0;
    rx_bit_s      = 1'b0;
    rx_last_s     = 1'b0;
    result_take_s = 1'b0;
    tx_end_s      = 1'b0;
    tx_bit_s      = 1'b0;
    rx_shift_s    = {rx_sreg_r, mosi};
    case (state_r)
      S_IDLE: begin
        if (!cs_n && armed_r) begin
          frame_begin_s = 1'b1;
        end else begin
          frame_begin_s = 1'b0;
        end
      end
      S_RX: begin
        if (cs_n) begin
          rx_abort_s = 1'b1;
        end else if (cnt_r == RX_LAST) begin
          rx_last_s = 1'b1;
        end else begin
          rx_bit_s = 1'b1;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          result_take_s = 1'b1;
        end else begin
          result_take_s = 1'b0;
        end
      end
      S_TX: begin
        if (cnt_r == TX_LAST) begin
          tx_end_s = 1'b1;
        end else begin
          tx_bit_s = 1'b1;
        end
      end
      default: begin
        frame_begin_s = 1'b0;
      end
    endcase
  end

  // Next-state selection for the transfer FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (frame_begin_s) begin
          state_s = S_RX;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RX: begin
        if (rx_abort_s) begin
          state_s = S_IDLE;
        end else if (rx_last_s) begin
          state_s = S_START;
        end else begin
          state_s = S_RX;
        end
      end
      S_START: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (result_take_s) begin
          state_s = S_TX;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_TX: begin
        if (tx_end_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_TX;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Arm flag: a frame may start only after cs_n has been seen high in IDLE,
  // so a chip select left low from the previous frame cannot restart one.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      armed_r <= 1'b0;
    end else if (state_r == S_IDLE) begin
      if (cs_n) begin
        armed_r <= 1'b1;
      end else if (frame_begin_s) begin
        armed_r <= 1'b0;
      end
    end else if (rx_abort_s) begin
      armed_r <= 1'b1;
    end
  end

  // Shared bit counter: frame bits sampled in RX, result bits driven in TX.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (frame_begin_s || result_take_s) begin
      cnt_r <= CNT_ONE;
    end else if (rx_bit_s || tx_bit_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (rx_abort_s || rx_last_s || tx_end_s) begin
      cnt_r <= CNT_ZERO;
    end
  end

  // Receive shift register; a new frame starts from a clean register.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      rx_sreg_r <= {(FRM_W-1){1'b0}};
    end else if (frame_begin_s) begin
      rx_sreg_r <= {{(FRM_W-2){1'b0}}, mosi};
    end else if (rx_bit_s) begin
      rx_sreg_r <= rx_shift_s[FRM_W-2:0];
    end else if (rx_abort_s) begin
      rx_sreg_r <= {(FRM_W-1){1'b0}};
    end
  end

  // Core operands load on the edge that samples the final frame bit and then
  // stay put until the next complete frame.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      core_msg_r <= {MSG_W{1'b0}};
      core_key_r <= {KEY_W{1'b0}};
    end else if (rx_last_s) begin
      core_msg_r <= rx_shift_s[FRM_W-1:KEY_W];
      core_key_r <= rx_shift_s[KEY_W-1:0];
    end
  end

  // One-cycle start pulse covering exactly the START state.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      core_start_r <= 1'b0;
    end else begin
      core_start_r <= rx_last_s;
    end
  end

  // Result serialiser: MSB goes out on the capture edge, the rest follow.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      tx_sreg_r   <= {MSG_W{1'b0}};
      miso_r      <= 1'b0;
      data_done_r <= 1'b0;
    end else if (result_take_s) begin
      tx_sreg_r   <= {core_result[MSG_W-2:0], 1'b0};
      miso_r      <= core_result[MSG_W-1];
      data_done_r <= 1'b1;
    end else if (tx_bit_s) begin
      tx_sreg_r   <= {tx_sreg_r[MSG_W-2:0], 1'b0};
      miso_r      <= tx_sreg_r[MSG_W-1];
      data_done_r <= 1'b1;
    end else if (tx_end_s) begin
      tx_sreg_r   <= {MSG_W{1'b0}};
      miso_r      <= 1'b0;
      data_done_r <= 1'b0;
    end
  end

  // Status outputs: busy follows the next state, rx_err flags an aborted frame.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      busy_r   <= 1'b0;
      rx_err_r <= 1'b0;
    end else begin
      busy_r   <= (state_s != S_IDLE);
      rx_err_r <= rx_abort_s;
    end
  end

  assign miso       = miso_r;
  assign data_done  = data_done_r;
  assign core_start = core_start_r;
  assign core_msg   = core_msg_r;
  assign core_key   = core_key_r;
  assign busy       = busy_r;
  assign rx_err     = rx_err_r;

endmodule
